// File: rtl/sync_req_ack_ctrl_if.sv
// Upstream valid/ready payload port plus 4-phase req/ack link for sync_req_ack_ctrl.
// timeout_o exists only when SYNC_REQ_ACK_CTRL_TIMEOUT_EN is defined.
interface sync_req_ack_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  async_req_o;
    logic                  async_ack_i;
    logic [DATA_WIDTH-1:0] async_data_o;
    logic                  busy_o;
`ifdef SYNC_REQ_ACK_CTRL_TIMEOUT_EN
    logic                  timeout_o;
`endif

    // Controller side
    modport slave (
        input  valid_i, data_i, async_ack_i,
`ifdef SYNC_REQ_ACK_CTRL_TIMEOUT_EN
        output timeout_o,
`endif
        output ready_o, async_req_o, async_data_o, busy_o
    );

    // Upstream producer together with the remote acknowledger
    modport master (
        output valid_i, data_i, async_ack_i,
`ifdef SYNC_REQ_ACK_CTRL_TIMEOUT_EN
        input  timeout_o,
`endif
        input  ready_o, async_req_o, async_data_o, busy_o
    );
endinterface

// File: rtl/sync_req_ack_ctrl.sv
// 4-phase request/acknowledge source: accepts one payload, holds it on flops and
// handshakes it to a remote domain. Optional timeout: SYNC_REQ_ACK_CTRL_TIMEOUT_EN.
module sync_req_ack_ctrl #(
    parameter int STAGES         = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                clk_i,
    input logic                rst_i,
    sync_req_ack_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                r_state;
    logic [STAGES-1:0]     r_sync;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_ack_s;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_timeout;

    assign w_ack_s = r_sync[STAGES-1];
    // A stale ack left over from an aborted handshake blocks new transfers.
    assign w_ready = (r_state == IDLE) && !w_ack_s && !rst_i;
    assign w_xfer  = bus.valid_i && w_ready;

    // Ack synchronizer chain; the last stage is the only one the FSM looks at
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], bus.async_ack_i};
        end
    end

`ifdef SYNC_REQ_ACK_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        r_timeout;

    // A handshake completing on the limit cycle wins over the timeout.
    assign w_timeout = (r_state != IDLE) && (r_to_cnt == TO_LAST) &&
                       !((r_state == REQ_LO) && !w_ack_s);

    // Handshake duration counter, parked at zero while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt <= 16'd0;
        end else if ((r_state == IDLE) || w_timeout) begin
            r_to_cnt <= 16'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // Single-cycle timeout pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    // Handshake FSM; request and payload are registered alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_state <= REQ_HI;
                        r_req   <= 1'b1;
                        r_data  <= bus.data_i;
                    end
                end
                REQ_HI: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end else if (w_ack_s) begin
                        r_state <= REQ_LO;
                        r_req   <= 1'b0;
                    end
                end
                REQ_LO: begin
                    if (!w_ack_s || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o      = w_ready;
    assign bus.busy_o       = (r_state != IDLE) && !rst_i;
    assign bus.async_req_o  = r_req;
    assign bus.async_data_o = r_data;

endmodule
